// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative MIPS32 multiply/divide unit. Owns the HI/LO architectural
// registers, runs MULT/MULTU/DIV/DIVU as one radix-2 step per clock and
// services MTHI/MTLO writes while idle.
//
// Optional feature: define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
// (Op 1xx), which accumulate the product into {HI,LO}. Without it, Op 1xx
// is rejected and Start is ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   Start      operation request, accepted only when idle
//   Op         000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 1xx accumulate ops
//   InputA     rs operand (multiplicand / dividend)
//   InputB     rt operand (multiplier / divisor)
//   Flush      abort the in-flight operation
//   HiWrite    MTHI strobe (idle only)
//   LoWrite    MTLO strobe (idle only)
//   WriteData  MTHI/MTLO data
//   Busy       operation in flight, stalls the pipeline
//   Done       one-cycle pulse when HI/LO have been updated
//   HiOut      HI register
//   LoOut      LO register
// -----------------------------------------------------------------------------
module mult_div_unit #(
   parameter int ITER = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Start,
   input  logic [2:0]  Op,
   input  logic [31:0] InputA,
   input  logic [31:0] InputB,
   input  logic        Flush,
   input  logic        HiWrite,
   input  logic        LoWrite,
   input  logic [31:0] WriteData,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] HiOut,
   output logic [31:0] LoOut
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam int         CNT_W  = $clog2(ITER + 1);

   function automatic logic [31:0] f_cneg32(input logic [31:0] v, input logic en);
      return en ? (32'd0 - v) : v;
   endfunction

   function automatic logic [63:0] f_cneg64(input logic [63:0] v, input logic en);
      return en ? (64'd0 - v) : v;
   endfunction

   // control
   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;

   // datapath: r_p holds {remainder, quotient} for divide, the running
   // product for multiply; r_m holds the divisor / multiplicand.
   logic [63:0]      r_p;
   logic [31:0]      r_m;
   logic             r_is_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_divz;
`ifdef MULDIV_MADD_EN
   logic             r_acc;
   logic             r_sub;
`endif

   logic signed [31:0] w_a_s;
   logic signed [31:0] w_b_s;
   logic               w_op_valid;
   logic               w_accept;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [32:0]        w_mul_sum;
   logic [63:0]        w_mul_next;
   logic [32:0]        w_div_shift;
   logic [32:0]        w_div_diff;
   logic [63:0]        w_div_next;
   logic [63:0]        w_prod;
   logic [31:0]        w_quo;
   logic [31:0]        w_rem;
   logic [63:0]        w_hilo;

`ifdef MULDIV_MADD_EN
   assign w_op_valid = 1'b1;
`else
   assign w_op_valid = ~Op[2];
`endif

   assign w_a_s    = InputA;
   assign w_b_s    = InputB;
   assign w_a_neg  = ~Op[0] & (w_a_s < 0);
   assign w_b_neg  = ~Op[0] & (w_b_s < 0);
   assign w_accept = (r_state == S_IDLE) & Start & w_op_valid & ~Flush;

   // multiply step: conditionally add multiplicand to the upper half, then
   // shift the whole 65-bit result right by one
   assign w_mul_sum  = {1'b0, r_p[63:32]} + {1'b0, (r_p[0] ? r_m : 32'd0)};
   assign w_mul_next = {w_mul_sum, r_p[31:1]};

   // restoring divide step: a borrow out of bit 32 means the trial subtract
   // failed, so keep the shifted remainder and shift in a 0 quotient bit
   assign w_div_shift = {r_p[63:32], r_p[31]};
   assign w_div_diff  = w_div_shift - {1'b0, r_m};
   assign w_div_next  = w_div_diff[32] ? {w_div_shift[31:0], r_p[30:0], 1'b0}
                                       : {w_div_diff[31:0],  r_p[30:0], 1'b1};

   assign w_prod = f_cneg64(r_p, r_neg_q);
   assign w_quo  = f_cneg32(r_p[31:0], r_neg_q);
   assign w_rem  = f_cneg32(r_p[63:32], r_neg_r);
   assign w_hilo = {r_hi, r_lo};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (HiWrite) r_hi <= WriteData;
               if (LoWrite) r_lo <= WriteData;
               if (w_accept) begin
                  r_state <= S_CALC;
                  r_cnt   <= '0;
               end
            end
            S_CALC: begin
               if (Flush) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_W'(ITER - 1)) r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_state <= S_IDLE;
               if (!Flush) begin
                  r_done <= 1'b1;
                  if (r_is_div) begin
                     r_lo <= r_divz ? 32'hFFFF_FFFF : w_quo;
                     r_hi <= w_rem;
                  end else begin
`ifdef MULDIV_MADD_EN
                     if (r_acc)
                        {r_hi, r_lo} <= r_sub ? (w_hilo - w_prod) : (w_hilo + w_prod);
                     else
                        {r_hi, r_lo} <= w_prod;
`else
                     {r_hi, r_lo} <= w_prod;
`endif
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // operands are captured as magnitudes; signs are restored in FIX
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_p      <= {32'd0, f_cneg32(InputA, w_a_neg)};
         r_m      <= f_cneg32(InputB, w_b_neg);
         r_is_div <= ~Op[2] & Op[1];
         r_neg_q  <= w_a_neg ^ w_b_neg;
         r_neg_r  <= w_a_neg;
         r_divz   <= (InputB == 32'd0);
`ifdef MULDIV_MADD_EN
         r_acc    <= Op[2];
         r_sub    <= Op[1];
`endif
      end else if (r_state == S_CALC) begin
         r_p <= r_is_div ? w_div_next : w_mul_next;
      end
   end

   // Busy rises one cycle after acceptance and covers the ITER-1 remaining
   // CALC cycles plus FIX
   assign Busy  = (r_state == S_FIX) | ((r_state == S_CALC) & (r_cnt != '0));
   assign Done  = r_done;
   assign HiOut = r_hi;
   assign LoOut = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] InputA;
   logic [31:0] InputB;
   logic        Flush;
   logic        HiWrite;
   logic        LoWrite;
   logic [31:0] WriteData;
   logic        Busy;
   logic        Done;
   logic [31:0] HiOut;
   logic [31:0] LoOut;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mult_div_unit #(.ITER(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .Start     (Start),
      .Op        (Op),
      .InputA    (InputA),
      .InputB    (InputB),
      .Flush     (Flush),
      .HiWrite   (HiWrite),
      .LoWrite   (LoWrite),
      .WriteData (WriteData),
      .Busy      (Busy),
      .Done      (Done),
      .HiOut     (HiOut),
      .LoOut     (LoOut)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_hl(input logic hi, input logic [31:0] d);
      HiWrite   = hi;
      LoWrite   = ~hi;
      WriteData = d;
      tick();
      HiWrite   = 1'b0;
      LoWrite   = 1'b0;
   endtask

   // issue one op, scramble operands after acceptance, wait (bounded) for Done
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int nbusy);
      Op     = op;
      InputA = a;
      InputB = b;
      Start  = 1'b1;
      tick();
      Start  = 1'b0;
      InputA = 32'hDEAD_BEEF;
      InputB = 32'h0BAD_F00D;
      lat    = 0;
      nbusy  = 0;
      if (Busy) nbusy++;
      while (lat < 40) begin
         tick();
         lat++;
         if (Busy) nbusy++;
         if (Done) break;
      end
   endtask

   int lat;
   int nbusy;
   int ndone;

   initial begin
      rst = 1'b1; Start = 1'b0; Op = 3'd0; InputA = '0; InputB = '0;
      Flush = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0; WriteData = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_hi", HiOut, 32'h0);
      check("rst_lo", LoOut, 32'h0);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check("rst_done", {31'd0, Done}, 32'd0);

      // MULT -3 * 5 = -15
      run_op(3'b000, 32'hFFFF_FFFD, 32'd5, lat, nbusy);
      check("mult_lat", 32'(lat), 32'd33);
      check("mult_busy_cycles", 32'(nbusy), 32'd32);
      check("mult_hi", HiOut, 32'hFFFF_FFFF);
      check("mult_lo", LoOut, 32'hFFFF_FFF1);
      tick();
      check("done_pulse_width", {31'd0, Done}, 32'd0);

      // MULTU max * max = FFFFFFFE_00000001
      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nbusy);
      check("multu_hi", HiOut, 32'hFFFF_FFFE);
      check("multu_lo", LoOut, 32'h0000_0001);

      // DIVU 100 / 7
      run_op(3'b011, 32'd100, 32'd7, lat, nbusy);
      check("divu_lat", 32'(lat), 32'd33);
      check("divu_lo", LoOut, 32'd14);
      check("divu_hi", HiOut, 32'd2);

      // DIV -7 / 2 = -3 rem -1
      run_op(3'b010, 32'hFFFF_FFF9, 32'd2, lat, nbusy);
      check("div_neg_lo", LoOut, 32'hFFFF_FFFD);
      check("div_neg_hi", HiOut, 32'hFFFF_FFFF);

      // DIV 7 / -2 = -3 rem 1
      run_op(3'b010, 32'd7, 32'hFFFF_FFFE, lat, nbusy);
      check("div_negb_lo", LoOut, 32'hFFFF_FFFD);
      check("div_negb_hi", HiOut, 32'd1);

      // DIVU 123 / 0
      run_op(3'b011, 32'd123, 32'd0, lat, nbusy);
      check("divz_lat", 32'(lat), 32'd33);
      check("divz_lo", LoOut, 32'hFFFF_FFFF);
      check("divz_hi", HiOut, 32'd123);

      // DIV -5 / 0
      run_op(3'b010, 32'hFFFF_FFFB, 32'd0, lat, nbusy);
      check("sdivz_lo", LoOut, 32'hFFFF_FFFF);
      check("sdivz_hi", HiOut, 32'hFFFF_FFFB);

      // DIV overflow
      run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, lat, nbusy);
      check("dovf_lo", LoOut, 32'h8000_0000);
      check("dovf_hi", HiOut, 32'h0);

      // MTHI / MTLO, then flush mid-operation
      write_hl(1'b1, 32'hAAAA_0000);
      write_hl(1'b0, 32'h0000_5555);
      check("mthi", HiOut, 32'hAAAA_0000);
      check("mtlo", LoOut, 32'h0000_5555);
      Op = 3'b001; InputA = 32'd2; InputB = 32'd3; Start = 1'b1;
      tick();
      Start = 1'b0;
      repeat (10) tick();
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      check("flush_busy", {31'd0, Busy}, 32'd0);
      ndone = 0;
      repeat (40) begin
         tick();
         if (Done) ndone++;
      end
      check("flush_no_done", 32'(ndone), 32'd0);
      check("flush_hi", HiOut, 32'hAAAA_0000);
      check("flush_lo", LoOut, 32'h0000_5555);

      // Flush in IDLE drops Start
      Op = 3'b001; Start = 1'b1; Flush = 1'b1;
      tick();
      Start = 1'b0; Flush = 1'b0;
      tick();
      check("idle_flush_busy", {31'd0, Busy}, 32'd0);

      // MTHI while busy is ignored
      Op = 3'b001; InputA = 32'd2; InputB = 32'd3; Start = 1'b1;
      tick();
      Start = 1'b0;
      repeat (5) tick();
      write_hl(1'b1, 32'h1234_5678);
      check("busy_mthi_hi", HiOut, 32'hAAAA_0000);
      ndone = 0;
      repeat (40) begin
         tick();
         if (Done) ndone++;
      end
      check("busy_mthi_done", 32'(ndone), 32'd1);
      check("multu_small_hi", HiOut, 32'h0);
      check("multu_small_lo", LoOut, 32'd6);

      // Start held with new Op while busy: one Done only
      Op = 3'b001; InputA = 32'd4; InputB = 32'd5; Start = 1'b1;
      tick();
      Op = 3'b011; InputA = 32'd100; InputB = 32'd7;
      ndone = 0;
      repeat (20) begin
         tick();
         if (Done) ndone++;
      end
      Start = 1'b0;
      repeat (30) begin
         tick();
         if (Done) ndone++;
      end
      check("held_start_dones", 32'(ndone), 32'd1);
      check("held_start_hi", HiOut, 32'h0);
      check("held_start_lo", LoOut, 32'd20);

      // reset mid-operation
      write_hl(1'b1, 32'h0000_1111);
      write_hl(1'b0, 32'h0000_2222);
      Op = 3'b000; InputA = 32'd9; InputB = 32'd9; Start = 1'b1;
      tick();
      Start = 1'b0;
      repeat (20) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_hi", HiOut, 32'h0);
      check("mid_rst_lo", LoOut, 32'h0);
      check("mid_rst_busy", {31'd0, Busy}, 32'd0);
      ndone = 0;
      repeat (40) begin
         tick();
         if (Done) ndone++;
      end
      check("mid_rst_no_done", 32'(ndone), 32'd0);

`ifdef MULDIV_MADD_EN
      write_hl(1'b1, 32'h0);
      write_hl(1'b0, 32'h10);
      run_op(3'b100, 32'd3, 32'd4, lat, nbusy);
      check("madd_lat", 32'(lat), 32'd33);
      check("madd_hi", HiOut, 32'h0);
      check("madd_lo", LoOut, 32'h1C);
      run_op(3'b111, 32'd1, 32'h1D, lat, nbusy);
      check("msubu_hi", HiOut, 32'hFFFF_FFFF);
      check("msubu_lo", LoOut, 32'hFFFF_FFFF);
`else
      write_hl(1'b1, 32'h0000_0077);
      Op = 3'b100; InputA = 32'd3; InputB = 32'd4; Start = 1'b1;
      tick();
      Start = 1'b0;
      nbusy = 0;
      ndone = 0;
      repeat (40) begin
         tick();
         if (Busy) nbusy++;
         if (Done) ndone++;
      end
      check("op1xx_busy", 32'(nbusy), 32'd0);
      check("op1xx_done", 32'(ndone), 32'd0);
      check("op1xx_hi", HiOut, 32'h0000_0077);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit for the MIPS32 EX stage. Owns the HI/LO architectural registers, executes MULT/MULTU/DIV/DIVU over multiple cycles, and services MTHI/MTLO writes. HiOut/LoOut feed the downstream 32-bit 4-to-1 writeback result selector, alongside the ALU and memory data. Busy stalls the pipeline.

Parameters:
ITER, 32, iteration cycles per operation (operand width; fixed at 32 for MIPS32)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
Start  input  1  request an operation; accepted only in IDLE
Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 1xx accumulate ops (see Optional Feature)
InputA  input  32  rs operand (multiplicand / dividend)
InputB  input  32  rt operand (multiplier / divisor)
Flush  input  1  abort the in-flight operation (exception/branch squash)
HiWrite  input  1  MTHI strobe
LoWrite  input  1  MTLO strobe
WriteData  input  32  data for MTHI/MTLO
Busy  output  1  operation in flight
Done  output  1  one-cycle pulse; HI/LO updated
HiOut  output  32  current HI register
LoOut  output  32  current LO register

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, HI=0, LO=0, Busy=0, Done=0, counter=0. Reset mid-operation discards the operation.
- States: IDLE, CALC, FIX.
- IDLE: on an edge with Start=1 and a valid Op, latch |A| and |B| (for signed ops) or raw values (for unsigned ops). Latch result-sign flags. Clear counter. Go to CALC. Busy=1 from the next cycle.
- CALC: one radix-2 step per edge:
  - Multiply: shift-add on a 64-bit product.
  - Divide: restoring shift-subtract on a 32-bit remainder and 32-bit quotient.
  - counter increments each edge; after ITER edges go to FIX.
- FIX: single edge that:
  - applies two's-complement sign correction (product sign = A xor B; quotient sign = A xor B; remainder sign = sign of A);
  - writes HI/LO;
  - asserts Done for exactly the following cycle;
  - returns to IDLE with Busy=0.
- Latency: if Start is accepted at edge E0, HI/LO are visible and Done=1 after edge E(ITER+1) = E33. Busy is high after E1 through E32 inclusive.
- Results:
  - Multiply: {HI,LO} = 64-bit product.
  - Divide: LO = quotient, HI = remainder (truncating toward zero).
- Divide by zero: completes with normal latency; LO=32'hFFFFFFFF, HI=InputA as latched raw, signed or unsigned.
- Signed overflow (DIV 32'h80000000 / 32'hFFFFFFFF): LO=32'h80000000, HI=0.
- Start while Busy: ignored; the pipeline must be stalled on Busy.
- Flush: in CALC or FIX, go to IDLE on that edge. HI/LO are unchanged, no Done, Busy=0 next cycle. Flush in IDLE takes priority over Start (Start is dropped).
- HiWrite/LoWrite: honoured only in IDLE; write WriteData on the edge and ignored while Busy. If HiWrite/LoWrite and Start occur in the same IDLE edge, both take effect; the operation result later overwrites HI/LO.
- Operands are sampled only at acceptance; later changes on InputA/InputB have no effect.
- HiOut/LoOut are direct register outputs with no combinational path from inputs.

Optional Feature:
Macro MULDIV_MADD_EN.
- Defined: Op 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU are valid.
  - Multiply proceeds as for MULT/MULTU.
  - In FIX, {HI,LO} <= {HI,LO} + product (MADD/MADDU) or {HI,LO} - product (MSUB/MSUBU), modulo 2^64.
  - Latency is identical.
  - {HI,LO} as sampled at FIX is used, since MTHI/MTLO are blocked while Busy.
- Not defined: Op 1xx is invalid. Start with Op 1xx is ignored: no Busy, no Done, HI/LO unchanged.

Test Plan:
- Reset then MULT A=32'hFFFFFFFD (-3), B=5 -> Done 33 cycles after acceptance; HI=32'hFFFFFFFF, LO=32'hFFFFFFF1; Busy high for exactly 32 cycles.
- DIVU A=100, B=7 -> LO=14, HI=2. DIV A=-7, B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIVU A=123, B=0 -> LO=32'hFFFFFFFF, HI=123 at normal latency. DIV A=32'h80000000, B=-1 -> LO=32'h80000000, HI=0.
- MTHI 32'hAAAA0000 and MTLO 32'h5555; start MULTU 2*3; assert Flush in iteration 10 -> Busy=0 next cycle, no Done, HI=32'hAAAA0000, LO=32'h5555. Then HiWrite asserted while Busy -> HI unchanged.
- Start held high with a new Op during Busy -> ignored; exactly one Done per accepted Start. rst asserted in iteration 20 -> HI=LO=0, Busy=0 next cycle.
- With MULDIV_MADD_EN: HI=0, LO=32'h10, MADD 3*4 -> LO=32'h1C, HI=0; then MSUBU 1*32'h1D -> HI=LO=32'hFFFFFFFF. Without the macro: Op=100 -> Busy stays 0.
